// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: streams WORDS-wide operands through one external 16-bit adder, LSW first.
module wide_add_sequencer #(
  parameter int WORDS = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORDS*WIDTH-1:0] in_a,
  input  logic [WORDS*WIDTH-1:0] in_b,
  input  logic                   in_cin,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  output logic                   add_cin,
  input  logic [WIDTH-1:0]       add_sum,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORDS*WIDTH-1:0] out_sum,
  output logic                   out_cout,
  output logic                   out_ovf
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int W = WORDS * WIDTH;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] a_reg, b_reg;
  logic [W-WIDTH-1:0] sum_reg;
  logic carry_reg;
  logic [IW-1:0] idx;
  logic accept;
  assign accept = in_valid && in_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    in_ready = 1'b0;
    out_valid = 1'b0;
    add_a = '0;
    add_b = '0;
    add_cin = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        state_n = in_valid ? RUN : IDLE;
      end
      RUN: begin
        add_a = a_reg[idx*WIDTH +: WIDTH];
        add_b = b_reg[idx*WIDTH +: WIDTH];
        add_cin = carry_reg;
        state_n = (idx == LAST) ? DONE : RUN;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready = out_ready;
        state_n = !out_ready ? DONE : in_valid ? RUN : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // Published result is loaded only on DONE entry so it stays put through the next RUN.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      sum_reg <= '0;
      carry_reg <= 1'b0;
      idx <= '0;
      out_sum <= '0;
      out_cout <= 1'b0;
      out_ovf <= 1'b0;
    end else if (accept) begin
      a_reg <= in_a;
      b_reg <= in_b;
      carry_reg <= in_cin;
      idx <= '0;
    end else if (state == RUN) begin
      carry_reg <= add_cout;
      idx <= idx + 1'b1;
      if (idx == LAST) begin
        out_sum <= {add_sum, sum_reg};
        out_cout <= add_cout;
        out_ovf <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[WIDTH-1] != a_reg[W-1]);
      end else sum_reg[idx*WIDTH +: WIDTH] <= add_sum;
    end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: directed vectors with a result scoreboard; bench models the 16-bit adder.
module tb_wide_add_sequencer;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, in_cin = 0, out_ready = 1;
  logic [63:0] in_a = '0, in_b = '0, out_sum;
  logic [15:0] add_a, add_b, add_sum;
  logic add_cin, add_cout, out_valid, out_cout, out_ovf;
  typedef struct {logic [63:0] sum; logic cout; logic ovf;} exp_t;
  exp_t q[$];
  int n = 0, errs = 0;

  wide_add_sequencer #(.WORDS(4), .WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf));

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_result", out_sum, 64'hx);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("out_sum", out_sum, e.sum);
        chk("out_cout", out_cout, e.cout);
        chk("out_ovf", out_ovf, e.ovf);
      end
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] a, b, input logic c, input logic [63:0] es, input logic ec, eo);
    int k = 0;
    in_a = a; in_b = b; in_cin = c; in_valid = 1;
    q.push_back('{es, ec, eo});
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic wait_result(input string nm, input int exp_c);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!out_valid && c < 50);
    chk(nm, c, exp_c);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] cins;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_add_a", {add_a, add_b, 15'd0, add_cin}, 0);
    step();
    rst_n = 1;
    #1 chk("rst_in_ready", in_ready, 1);
    step();
    send(64'h0000_0000_0000_FFFF, 64'h1, 0, 64'h0000_0000_0001_0000, 0, 0);
    wait_result("latency1", 5);
    step();
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 64'h0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cins[i] = add_cin;
    end
    chk("run_add_cin", cins, 4'b1111);
    @(negedge clk);
    chk("valid2", out_valid, 1);
    step();
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0, 64'h8000_0000_0000_0000, 0, 1);
    wait_result("latency3", 5);
    step();
    out_ready = 0;
    send(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 0, 64'h2345_6789_ABCD_F001, 0, 0);
    wait_result("latency4a", 5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", out_sum, 64'h2345_6789_ABCD_F001);
      chk("bp_in_ready", in_ready, 0);
    end
    step();
    out_ready = 1;
    send(64'h1, 64'h2, 0, 64'h3, 0, 0);
    wait_result("latency4b", 5);
    step();
    send(64'h1111_2222_3333_4444, 64'h0101_0202_0303_0404, 0, 64'h1212_2424_3636_4848, 0, 0);
    repeat (3) @(negedge clk);
    chk("idx2_add_a", add_a, 16'h2222);
    #1 rst_n = 0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_add", {add_a, add_b, 15'd0, add_cin}, 0);
    q.delete();
    step();
    step();
    rst_n = 1;
    #1 chk("postrst_in_ready", in_ready, 1);
    step();
    send(64'h5, 64'h5, 0, 64'hA, 0, 0);
    wait_result("latency5", 5);
    step();
    send(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 0, 64'h0011_0022_0033_0044, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      in_valid = (i != 1);
      in_a = 64'hDEAD_DEAD_DEAD_DEAD;
      in_b = 64'hBEEF_BEEF_BEEF_BEEF;
    end
    in_valid = 0;
    wait_result("latency6", 2);
    step();
    step();
    chk("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-word adder controller that feeds a 16-bit ripple-carry adder one word per cycle, least significant word first.
- Feeds the adder's carry-out back as the next word's carry-in, so one 16-bit adder serves WORDS*16-bit operands.
- Sits directly upstream of the adder and also consumes its sum/carry.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
WORDS  4  number of 16-bit words per operand; legal range 2..16
WIDTH  16  adder word width; fixed to match the 16-bit adder, not to be overridden

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair offered
in_ready  output  1  block can accept operands this cycle
in_a  input  WORDS*WIDTH  operand A, word 0 = bits [15:0]
in_b  input  WORDS*WIDTH  operand B
in_cin  input  1  carry-in to word 0
add_a  output  WIDTH  to adder A
add_b  output  WIDTH  to adder B
add_cin  output  1  to adder carry-in
add_sum  input  WIDTH  from adder Sum (combinational)
add_cout  input  1  from adder Carry (combinational)
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_sum  output  WORDS*WIDTH  assembled sum
out_cout  output  1  carry-out of most significant word
out_ovf  output  1  signed overflow of full-width add

Behaviour:
- **States:** IDLE, RUN, DONE. Word index idx is ceil(log2(WORDS)) bits wide.
- **Reset (async, rst_n=0):**
  - State goes to IDLE; idx, carry register, operand registers and sum registers clear to 0.
  - out_valid=0, out_cout=0, out_ovf=0, out_sum=0.
  - add_a, add_b and add_cin are 0; in_ready=1 once out of reset.
  - Reset mid-RUN or in DONE abandons the operation; no result is produced.
- **IDLE:**
  - in_ready=1; add_a, add_b and add_cin are driven 0.
  - On in_valid&&in_ready: capture in_a, in_b and in_cin into registers, set idx=0, go to RUN.
- **RUN:**
  - add_a = a_reg word[idx], add_b = b_reg word[idx], add_cin = carry_reg.
  - At each rising edge: sum_reg word[idx] <= add_sum, carry_reg <= add_cout, idx <= idx+1.
  - When idx==WORDS-1:
    - out_cout <= add_cout.
    - out_ovf <= (a MSB == b MSB) && (add_sum MSB != a MSB), using bit 15 of the top word.
    - Go to DONE.
  - in_ready=0; in_valid and in_a/in_b changes are ignored.
- **Latency:** acceptance edge T → out_valid=1 after edge T+WORDS (WORDS cycles in RUN).
- **DONE:**
  - out_valid=1; out_sum, out_cout and out_ovf are held stable while out_ready=0.
  - add_* driven 0.
  - in_ready = out_ready.
- **Leaving DONE:**
  - out_valid&&out_ready with no in_valid: go to IDLE.
  - out_valid&&out_ready&&in_valid (simultaneous): result retired and new operands captured on the same edge; go directly to RUN with idx=0. out_valid is 0 the next cycle.
- **Output holding:** out_sum, out_cout and out_ovf keep their last values after retirement until overwritten by the next DONE entry. They are meaningful only while out_valid=1.
- **Arithmetic:**
  - Unsigned result is {out_cout, out_sum} modulo 2^(WORDS*16+1).
  - No saturation.
  - Carry propagates across words only through carry_reg, with exactly one adder evaluation per cycle.
- **Adder interface:** the adder is purely combinational, so the block requires add_sum/add_cout to settle within one clk period. The block adds no wait states.

Test Plan (WORDS=4):
1. A=0x0000_0000_0000_FFFF, B=0x1, cin=0 → out_sum=0x0000_0000_0001_0000, out_cout=0, out_ovf=0; out_valid rises exactly 4 cycles after acceptance.
2. A=0xFFFF_FFFF_FFFF_FFFF, B=0x0, cin=1 → out_sum=0x0, out_cout=1, out_ovf=0; add_cin=1 observed on all 4 RUN cycles.
3. A=0x7FFF_FFFF_FFFF_FFFF, B=0x1, cin=0 → out_sum=0x8000_0000_0000_0000, out_cout=0, out_ovf=1.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE → outputs stable and in_ready=0 throughout. Then assert out_ready with in_valid=1 and new operands 0x1+0x2 → same-edge accept; next result is 0x3 after 4 more cycles.
5. Assert rst_n=0 while idx=2 in RUN → out_valid=0 and add_a/add_b/add_cin=0 immediately. After release, in_ready=1 and the next operation 0x5+0x5 yields 0xA.
6. During RUN, toggle in_valid and change in_a to 0xDEAD… → ignored; result equals the captured operands' sum.
